// File: rtl/instr_decode_dispatch.sv
// Buffers 64-bit instructions, decodes them and dispatches fetch / CLP-config requests; accept-to-valid 3 cycles.
// instr_ready drops only when the FIFO is full; optional macro DECODE_ERR_CNT_EN adds err_count/err_sticky.
module instr_decode_dispatch #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 16,
  parameter int MEM_CH     = 4,
  parameter int MAX_OUT    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [63:0]       instruction,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic [7:0]        fetch_type,
  output logic [ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [MEM_CH-1:0] mem_sel,
  output logic              feature_fetch_enable,
  output logic              weight_fetch_enable,
  input  logic              fetch_done,
  output logic              clp_valid,
  input  logic              clp_ready,
  output logic [7:0]        feature_size,
  output logic [15:0]       weight_mem_init_addr,
  output logic [15:0]       CLP_work_time,
  output logic [7:0]        scaler_mem_addr,
  output logic [2:0]        current_kernel_size,
  output logic              feature_in_select,
  output logic              feature_out_select,
  output logic [2:0]        CLP_type,
  output logic              illegal_opcode,
  output logic              idle
`ifdef DECODE_ERR_CNT_EN
  ,
  output logic [15:0]       err_count,
  output logic              err_sticky
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_FETCH = 8'h04;
  localparam logic [7:0] OP_CLP   = 8'h08;
  localparam logic [7:0] OP_SYNC  = 8'h10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_ISSUE_FETCH,
    S_ISSUE_CLP,
    S_WAIT_SYNC
  } state_t;

  state_t state_q;

  logic [63:0]      fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  logic [63:0]       dec_q;
  logic [7:0]        out_q;
  logic [7:0]        out_d;
  logic              fetch_vld_q;
  logic              clp_vld_q;
  logic              illegal_q;
  logic [7:0]        fetch_type_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [MEM_CH-1:0] mem_sel_q;
  logic [7:0]        feature_size_q;
  logic [15:0]       wmem_addr_q;
  logic [15:0]       work_time_q;
  logic [7:0]        scaler_q;
  logic [2:0]        kernel_q;
  logic              fin_sel_q;
  logic              fout_sel_q;
  logic [2:0]        clp_type_q;

  logic fetch_hs;
  logic done_eff;
  logic can_issue;
  logic mem_ok;

  assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign instr_ready = !fifo_full || pop;
  assign push        = instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= instruction;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push && pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Completions with nothing outstanding are spurious and dropped.
  assign fetch_hs = fetch_vld_q && fetch_ready;
  assign done_eff = fetch_done && (out_q != 8'd0);

  always_comb begin
    out_d = out_q;
    if (fetch_hs && !done_eff)      out_d = out_q + 8'd1;
    else if (!fetch_hs && done_eff) out_d = out_q - 8'd1;
  end

  assign can_issue = (out_d < 8'(MAX_OUT));
  assign mem_ok    = ({24'd0, dec_q[15:8]} < 32'(MEM_CH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      dec_q          <= '0;
      out_q          <= '0;
      fetch_vld_q    <= 1'b0;
      clp_vld_q      <= 1'b0;
      illegal_q      <= 1'b0;
      fetch_type_q   <= '0;
      src_q          <= '0;
      dst_q          <= '0;
      mem_sel_q      <= '0;
      feature_size_q <= '0;
      wmem_addr_q    <= '0;
      work_time_q    <= '0;
      scaler_q       <= '0;
      kernel_q       <= '0;
      fin_sel_q      <= 1'b0;
      fout_sel_q     <= 1'b0;
      clp_type_q     <= '0;
    end else begin
      out_q     <= out_d;
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            dec_q   <= fifo_mem_q[rd_ptr_q];
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (dec_q[63:56])
            OP_NOP: state_q <= S_IDLE;
            OP_FETCH: begin
              if (mem_ok) begin
                fetch_type_q <= dec_q[23:16];
                src_q        <= dec_q[40 +: ADDR_W];
                dst_q        <= dec_q[24 +: ADDR_W];
                mem_sel_q    <= MEM_CH'(1) << dec_q[15:8];
                fetch_vld_q  <= can_issue;
                state_q      <= S_ISSUE_FETCH;
              end else begin
                illegal_q <= 1'b1;
                state_q   <= S_IDLE;
              end
            end
            OP_CLP: begin
              feature_size_q <= dec_q[55:48];
              wmem_addr_q    <= dec_q[47:32];
              work_time_q    <= dec_q[31:16];
              scaler_q       <= dec_q[15:8];
              kernel_q       <= dec_q[7:5];
              fin_sel_q      <= dec_q[4];
              fout_sel_q     <= dec_q[3];
              clp_type_q     <= dec_q[2:0];
              clp_vld_q      <= 1'b1;
              state_q        <= S_ISSUE_CLP;
            end
            OP_SYNC: state_q <= S_WAIT_SYNC;
            default: begin
              illegal_q <= 1'b1;
              state_q   <= S_IDLE;
            end
          endcase
        end
        S_ISSUE_FETCH: begin
          if (fetch_hs) begin
            fetch_vld_q <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            fetch_vld_q <= can_issue;
          end
        end
        S_ISSUE_CLP: begin
          if (clp_ready) begin
            clp_vld_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        S_WAIT_SYNC: begin
          if (out_q == 8'd0) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fetch_valid          = fetch_vld_q;
  assign fetch_type           = fetch_type_q;
  assign src_addr             = src_q;
  assign dst_addr             = dst_q;
  assign mem_sel              = mem_sel_q;
  assign feature_fetch_enable = fetch_vld_q && !fetch_type_q[0];
  assign weight_fetch_enable  = fetch_vld_q && fetch_type_q[0];
  assign clp_valid            = clp_vld_q;
  assign feature_size         = feature_size_q;
  assign weight_mem_init_addr = wmem_addr_q;
  assign CLP_work_time        = work_time_q;
  assign scaler_mem_addr      = scaler_q;
  assign current_kernel_size  = kernel_q;
  assign feature_in_select    = fin_sel_q;
  assign feature_out_select   = fout_sel_q;
  assign CLP_type             = clp_type_q;
  assign illegal_opcode       = illegal_q;
  assign idle                 = fifo_empty && (state_q == S_IDLE) && (out_q == 8'd0);

`ifdef DECODE_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  logic        err_sticky_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
    end else if (illegal_q) begin
      err_sticky_q <= 1'b1;
      if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_count  = err_cnt_q;
  assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_instr_decode_dispatch.sv
// Bench for instr_decode_dispatch: vector table plus scoreboard of expected downstream transactions.
module tb_instr_decode_dispatch;

  localparam logic [1:0] K_FETCH = 2'd0;
  localparam logic [1:0] K_CLP   = 2'd1;
  localparam logic [1:0] K_ILL   = 2'd2;
  localparam logic [1:0] K_NONE  = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [63:0] instruction;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [7:0]  fetch_type;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [3:0]  mem_sel;
  logic        feature_fetch_enable;
  logic        weight_fetch_enable;
  logic        fetch_done;
  logic        clp_valid;
  logic        clp_ready;
  logic [7:0]  feature_size;
  logic [15:0] weight_mem_init_addr;
  logic [15:0] CLP_work_time;
  logic [7:0]  scaler_mem_addr;
  logic [2:0]  current_kernel_size;
  logic        feature_in_select;
  logic        feature_out_select;
  logic [2:0]  CLP_type;
  logic        illegal_opcode;
  logic        idle;
`ifdef DECODE_ERR_CNT_EN
  logic [15:0] err_count;
  logic        err_sticky;
`endif

  always #5 clk = ~clk;

  instr_decode_dispatch dut (
    .clk                  (clk),
    .rst                  (rst),
    .instr_valid          (instr_valid),
    .instr_ready          (instr_ready),
    .instruction          (instruction),
    .fetch_valid          (fetch_valid),
    .fetch_ready          (fetch_ready),
    .fetch_type           (fetch_type),
    .src_addr             (src_addr),
    .dst_addr             (dst_addr),
    .mem_sel              (mem_sel),
    .feature_fetch_enable (feature_fetch_enable),
    .weight_fetch_enable  (weight_fetch_enable),
    .fetch_done           (fetch_done),
    .clp_valid            (clp_valid),
    .clp_ready            (clp_ready),
    .feature_size         (feature_size),
    .weight_mem_init_addr (weight_mem_init_addr),
    .CLP_work_time        (CLP_work_time),
    .scaler_mem_addr      (scaler_mem_addr),
    .current_kernel_size  (current_kernel_size),
    .feature_in_select    (feature_in_select),
    .feature_out_select   (feature_out_select),
    .CLP_type             (CLP_type),
    .illegal_opcode       (illegal_opcode),
    .idle                 (idle)
`ifdef DECODE_ERR_CNT_EN
    ,
    .err_count            (err_count),
    .err_sticky           (err_sticky)
`endif
  );

  typedef struct {
    logic [1:0]  kind;
    logic [63:0] exp;
  } sb_t;

  typedef struct {
    logic [63:0] ins;
    logic [1:0]  kind;
    logic [63:0] exp;
  } vec_t;

  sb_t  sbq[$];
  vec_t vecs[10];

  int   errors = 0;
  int   checks = 0;
  int   n_fetch_hs = 0;
  int   n_clp_hs = 0;
  int   n_ill = 0;
  logic auto_done;
  logic hs_last;
  logic accepted;

  function automatic logic [63:0] fetch_bus();
    return {18'd0, fetch_type, src_addr, dst_addr, mem_sel, weight_fetch_enable, feature_fetch_enable};
  endfunction

  function automatic logic [63:0] clp_bus();
    return {8'd0, feature_size, weight_mem_init_addr, CLP_work_time, scaler_mem_addr,
            current_kernel_size, feature_in_select, feature_out_select, CLP_type};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic sb_pop(input logic [1:0] k, input logic [63:0] act);
    sb_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected: got kind %0d data %h expected no transaction", k, act);
    end else begin
      e = sbq.pop_front();
      chk("sb_kind", {62'd0, k}, {62'd0, e.kind});
      chk("sb_payload", act, e.exp);
    end
  endtask

  // One clock: observe at the falling edge, drive just after the rising edge.
  task automatic tick();
    @(negedge clk);
    accepted = instr_valid && instr_ready;
    hs_last  = fetch_valid && fetch_ready;
    if (rst) begin
      if (hs_last) begin
        n_fetch_hs++;
        sb_pop(K_FETCH, fetch_bus());
      end
      if (clp_valid && clp_ready) begin
        n_clp_hs++;
        sb_pop(K_CLP, clp_bus());
      end
      if (illegal_opcode) begin
        n_ill++;
        sb_pop(K_ILL, 64'd0);
      end
    end
    @(posedge clk);
    #1;
    fetch_done = auto_done && hs_last;
  endtask

  task automatic send(input logic [63:0] ins);
    int n;
    n = 0;
    instr_valid = 1'b1;
    instruction = ins;
    accepted    = 1'b0;
    while (!accepted && n < 50) begin
      tick();
      n++;
    end
    instr_valid = 1'b0;
    chk1("send_accepted", accepted, 1'b1);
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (!(idle && sbq.size() == 0) && n < max) begin
      tick();
      n++;
    end
    chk1("reach_idle", idle, 1'b1);
  endtask

  task automatic push_exp(input logic [1:0] k, input logic [63:0] e);
    sb_t s;
    s.kind = k;
    s.exp  = e;
    sbq.push_back(s);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ex1;
    int base;
    int n;

    vecs[0] = '{64'h04_1234_ABCD_00_00_00, K_FETCH, {18'd0, 8'h00, 16'h1234, 16'hABCD, 4'b0001, 1'b0, 1'b1}};
    vecs[1] = '{64'h04_FFFF_0001_03_03_00, K_FETCH, {18'd0, 8'h03, 16'hFFFF, 16'h0001, 4'b1000, 1'b1, 1'b0}};
    vecs[2] = '{64'h00_1111_2222_33_44_55, K_NONE,  64'd0};
    vecs[3] = '{64'h08_01_0002_0003_04_25, K_CLP,   {8'd0, 8'h01, 16'h0002, 16'h0003, 8'h04, 3'd1, 1'b0, 1'b0, 3'd5}};
    vecs[4] = '{64'hFF_0000_0000_00_00_00, K_ILL,   64'd0};
    vecs[5] = '{64'h10_0000_0000_00_00_00, K_NONE,  64'd0};
    vecs[6] = '{64'h04_0F0F_F0F0_FE_01_00, K_FETCH, {18'd0, 8'hFE, 16'h0F0F, 16'hF0F0, 4'b0010, 1'b0, 1'b1}};
    vecs[7] = '{64'h05_0000_0000_00_00_00, K_ILL,   64'd0};
    vecs[8] = '{64'h04_0000_0000_00_04_00, K_ILL,   64'd0};
    vecs[9] = '{64'h08_FF_FFFF_0000_FF_FF, K_CLP,   {8'd0, 8'hFF, 16'hFFFF, 16'h0000, 8'hFF, 3'd7, 1'b1, 1'b1, 3'd7}};

    rst         = 1'b0;
    instr_valid = 1'b0;
    instruction = 64'd0;
    fetch_ready = 1'b0;
    clp_ready   = 1'b0;
    fetch_done  = 1'b0;
    auto_done   = 1'b0;
    hs_last     = 1'b0;
    accepted    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_instr_ready", instr_ready, 1'b1);
    chk1("rst_idle", idle, 1'b1);
    chk1("rst_fetch_valid", fetch_valid, 1'b0);
    chk1("rst_clp_valid", clp_valid, 1'b0);
    chk1("rst_illegal", illegal_opcode, 1'b0);
    chk("rst_fetch_bus", fetch_bus(), 64'd0);
    chk("rst_clp_bus", clp_bus(), 64'd0);
`ifdef DECODE_ERR_CNT_EN
    chk("rst_err_count", {48'd0, err_count}, 64'd0);
`endif
    rst = 1'b1;
    tick();

    // Latency and payload stability under backpressure.
    ex1 = {18'd0, 8'h01, 16'h0001, 16'h0020, 4'b0100, 1'b1, 1'b0};
    send(64'h04_0001_0020_01_02_00);
    chk1("lat_fv_after_N", fetch_valid, 1'b0);
    tick();
    chk1("lat_fv_after_N1", fetch_valid, 1'b0);
    tick();
    chk1("lat_fv_after_N2", fetch_valid, 1'b1);
    chk("lat_payload", fetch_bus(), ex1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("hold_fv", fetch_valid, 1'b1);
      chk("hold_payload", fetch_bus(), ex1);
    end
    push_exp(K_FETCH, ex1);
    fetch_ready = 1'b1;
    tick();
    chk1("fv_drops_after_hs", fetch_valid, 1'b0);
    chk("payload_retained", {48'd0, src_addr}, 64'h0001);
    chk("hs_count_1", 64'(n_fetch_hs), 64'd1);
    fetch_done = 1'b1;
    tick();
    tick();
    chk1("idle_after_done", idle, 1'b1);

    // Outstanding limit: the fifth fetch waits for a completion.
    base = n_fetch_hs;
    for (int i = 0; i < 5; i++) begin
      push_exp(K_FETCH, {18'd0, 8'h01, 16'(i + 256), 16'h0000, 4'b0001, 1'b1, 1'b0});
      send({8'h04, 16'(i + 256), 16'h0000, 8'h01, 8'h00, 8'h00});
    end
    repeat (20) tick();
    chk("maxout_hs_4", 64'(n_fetch_hs - base), 64'd4);
    chk1("maxout_fv_low", fetch_valid, 1'b0);
    fetch_done = 1'b1;
    n = 0;
    while (n_fetch_hs - base < 5 && n < 10) begin
      tick();
      n++;
    end
    chk("maxout_hs_5", 64'(n_fetch_hs - base), 64'd5);
    for (int i = 0; i < 4; i++) begin
      fetch_done = 1'b1;
      tick();
      tick();
    end
    wait_idle(20);

    // SYNC holds the following CLP until outstanding drains.
    clp_ready = 1'b1;
    push_exp(K_FETCH, {18'd0, 8'h00, 16'h00AA, 16'h00BB, 4'b1000, 1'b0, 1'b1});
    push_exp(K_CLP, {8'd0, 8'hAB, 16'h1234, 16'h5678, 8'h9C, 3'd5, 1'b1, 1'b0, 3'd6});
    base = n_clp_hs;
    send(64'h04_00AA_00BB_00_03_00);
    send(64'h10_0000_0000_00_00_00);
    send(64'h08_AB_1234_5678_9C_B6);
    repeat (15) tick();
    chk("sync_clp_blocked", 64'(n_clp_hs - base), 64'd0);
    chk1("sync_clp_valid_low", clp_valid, 1'b0);
    fetch_done = 1'b1;
    n = 0;
    while (n_clp_hs == base && n < 10) begin
      tick();
      n++;
    end
    chk("sync_clp_issued", 64'(n_clp_hs - base), 64'd1);
    wait_idle(20);

    // Illegal opcode and out-of-range memory channel.
    base = n_fetch_hs;
    push_exp(K_ILL, 64'd0);
    push_exp(K_ILL, 64'd0);
    send(64'h7F_0000_0000_00_00_00);
    send(64'h04_0001_0002_00_05_00);
    wait_idle(20);
    repeat (2) tick();
    chk("ill_pulses", 64'(n_ill), 64'd2);
    chk("ill_no_fetch", 64'(n_fetch_hs - base), 64'd0);
`ifdef DECODE_ERR_CNT_EN
    chk("err_count_2", {48'd0, err_count}, 64'd2);
    chk1("err_sticky", err_sticky, 1'b1);
`endif

    // Simultaneous fetch handshake and completion keeps the count.
    base = n_fetch_hs;
    for (int i = 0; i < 2; i++) begin
      push_exp(K_FETCH, {18'd0, 8'h00, 16'(i + 16'h50), 16'h0000, 4'b0001, 1'b0, 1'b1});
      send({8'h04, 16'(i + 16'h50), 16'h0000, 8'h00, 8'h00, 8'h00});
    end
    n = 0;
    while (n_fetch_hs - base < 2 && n < 20) begin
      tick();
      n++;
    end
    fetch_ready = 1'b0;
    push_exp(K_FETCH, {18'd0, 8'h00, 16'h0060, 16'h0000, 4'b0001, 1'b0, 1'b1});
    send(64'h04_0060_0000_00_00_00);
    n = 0;
    while (!fetch_valid && n < 20) begin
      tick();
      n++;
    end
    chk1("same_fv_up", fetch_valid, 1'b1);
    fetch_ready = 1'b1;
    fetch_done  = 1'b1;
    tick();
    fetch_ready = 1'b0;
    chk("same_hs_count", 64'(n_fetch_hs - base), 64'd3);
    fetch_done = 1'b1;
    tick();
    tick();
    chk1("same_out_not_zero", idle, 1'b0);
    fetch_done = 1'b1;
    tick();
    tick();
    chk1("same_out_zero", idle, 1'b1);

    // Vector table with free-running downstream.
    auto_done   = 1'b1;
    fetch_ready = 1'b1;
    clp_ready   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].kind != K_NONE) push_exp(vecs[i].kind, vecs[i].exp);
      send(vecs[i].ins);
    end
    wait_idle(100);
    chk1("table_sb_empty", sbq.size() == 0, 1'b1);

    // Fill the FIFO behind a stalled CLP, then reset mid-handshake.
    auto_done = 1'b0;
    clp_ready = 1'b0;
    send(64'h08_11_2222_3333_44_00);
    n = 0;
    while (!clp_valid && n < 20) begin
      tick();
      n++;
    end
    chk1("fill_clp_valid", clp_valid, 1'b1);
    for (int i = 0; i < 4; i++) send(64'h00_0000_0000_00_00_00);
    instr_valid = 1'b1;
    instruction = 64'h00_0000_0000_00_00_00;
    tick();
    chk1("full_not_accepted", accepted, 1'b0);
    chk1("full_instr_ready", instr_ready, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk1("arst_clp_valid", clp_valid, 1'b0);
    chk1("arst_idle", idle, 1'b1);
    chk1("arst_instr_ready", instr_ready, 1'b1);
    instr_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    repeat (4) tick();
    chk1("post_rst_idle", idle, 1'b1);
    chk1("post_rst_clp_valid", clp_valid, 1'b0);
    chk1("post_rst_fetch_valid", fetch_valid, 1'b0);
    chk1("final_sb_empty", sbq.size() == 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
